// File: rtl/mc_core_pkg.sv
// +-----------------------------------------------------------------------------
// | mc_core_pkg : shared types and constants for the mc_core RV32I core
// | Rev 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

package mc_core_pkg;

  typedef enum logic [2:0] {
    ST_FETCH = 3'd0,
    ST_EXEC  = 3'd1,
    ST_MEM   = 3'd2,
    ST_WB    = 3'd3,
    ST_TRAP  = 3'd4
  } stage_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_t;

  localparam logic [3:0] TC_NONE        = 4'd0;
  localparam logic [3:0] TC_ILLEGAL     = 4'd1;
  localparam logic [3:0] TC_MISALIGN_PC = 4'd2;
  localparam logic [3:0] TC_MISALIGN_LD = 4'd3;
  localparam logic [3:0] TC_MISALIGN_ST = 4'd4;
  localparam logic [3:0] TC_BUS_TIMEOUT = 4'd5;
  localparam logic [3:0] TC_ECALL       = 4'd6;
  localparam logic [3:0] TC_EBREAK      = 4'd7;

  // funct7[5] selects SUB only in register form, but SRA in both forms
  function automatic alu_op_t alu_decode(input logic [2:0] f3, input logic f7b5,
                                         input logic is_reg);
    case (f3)
      3'b000:  alu_decode = (is_reg && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_decode = ALU_SLL;
      3'b010:  alu_decode = ALU_SLT;
      3'b011:  alu_decode = ALU_SLTU;
      3'b100:  alu_decode = ALU_XOR;
      3'b101:  alu_decode = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_decode = ALU_OR;
      default: alu_decode = ALU_AND;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mc_core_alu.sv
// +-----------------------------------------------------------------------------
// | mc_core_alu : combinational RV32I ALU with branch compare flags
// | Rev 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module mc_core_alu
  import mc_core_pkg::*;
(
  input  alu_op_t     i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_result,
  output logic        o_eq,
  output logic        o_lt,
  output logic        o_ltu
);

  logic [4:0] w_shamt;

  assign w_shamt = i_b[4:0];
  assign o_eq    = (i_a == i_b);
  assign o_lt    = ($signed(i_a) < $signed(i_b));
  assign o_ltu   = (i_a < i_b);

  always_comb begin
    o_result = 32'd0;
    case (i_op)
      ALU_ADD:  o_result = i_a + i_b;
      ALU_SUB:  o_result = i_a - i_b;
      ALU_SLL:  o_result = i_a << w_shamt;
      ALU_SLT:  o_result = {31'd0, o_lt};
      ALU_SLTU: o_result = {31'd0, o_ltu};
      ALU_XOR:  o_result = i_a ^ i_b;
      ALU_SRL:  o_result = i_a >> w_shamt;
      ALU_SRA:  o_result = $signed(i_a) >>> w_shamt;
      ALU_OR:   o_result = i_a | i_b;
      ALU_AND:  o_result = i_a & i_b;
      default:  o_result = 32'd0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mc_core.sv
// +-----------------------------------------------------------------------------
// | mc_core : multi-cycle RV32I core on a PicoRV32-native memory port
// | Optional retire trace port: define MC_CORE_TRACE_EN.   Rev 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module mc_core
  import mc_core_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          NUM_REGS    = 32,
  parameter int          BUS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        mem_valid,
  output logic        mem_instr,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic        halted,
  output logic [3:0]  trap_cause,
  output logic [31:0] peek
`ifdef MC_CORE_TRACE_EN
  ,
  output logic        retire_valid,
  output logic [31:0] retire_pc,
  output logic [31:0] retire_instr
`endif
);

  localparam int RIW = $clog2(NUM_REGS);
  localparam int TCW = $clog2(BUS_TIMEOUT + 2);

  stage_t         r_state, w_state_nxt;
  logic [31:0]    r_pc, r_instr, r_rdata;
  logic [3:0]     r_cause;
  logic [TCW-1:0] r_wait;
  logic [31:0]    r_regs [NUM_REGS];

  logic [6:0]  w_opc, w_f7;
  logic [4:0]  w_rd, w_rs1, w_rs2;
  logic [2:0]  w_f3;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [31:0] w_rs1_val, w_rs2_val, w_alu_a, w_alu_b, w_alu_res;
  logic [31:0] w_pc_plus4, w_next_pc, w_lane, w_load_val, w_wb_val;
  logic        w_legal, w_bad_reg, w_use_rd, w_use_rs1, w_use_rs2;
  logic        w_is_ld, w_is_st, w_is_br, w_ecall, w_ebreak;
  logic        w_eq, w_lt, w_ltu, w_taken, w_jump, w_ld_mis, w_st_mis;
  logic        w_bus_phase, w_waiting, w_expire;
  logic [3:0]  w_exec_cause, w_strb;
  alu_op_t     w_alu_op;

  assign w_opc = r_instr[6:0];
  assign w_rd  = r_instr[11:7];
  assign w_f3  = r_instr[14:12];
  assign w_rs1 = r_instr[19:15];
  assign w_rs2 = r_instr[24:20];
  assign w_f7  = r_instr[31:25];

  assign w_imm_i = {{20{r_instr[31]}}, r_instr[31:20]};
  assign w_imm_s = {{20{r_instr[31]}}, r_instr[31:25], r_instr[11:7]};
  assign w_imm_b = {{19{r_instr[31]}}, r_instr[31], r_instr[7], r_instr[30:25],
                    r_instr[11:8], 1'b0};
  assign w_imm_u = {r_instr[31:12], 12'd0};
  assign w_imm_j = {{11{r_instr[31]}}, r_instr[31], r_instr[19:12], r_instr[20],
                    r_instr[30:21], 1'b0};

  assign w_rs1_val = (w_rs1 == 5'd0) ? 32'd0 : r_regs[w_rs1[RIW-1:0]];
  assign w_rs2_val = (w_rs2 == 5'd0) ? 32'd0 : r_regs[w_rs2[RIW-1:0]];

  always_comb begin
    w_legal   = 1'b0;
    w_use_rd  = 1'b0;
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    w_is_ld   = 1'b0;
    w_is_st   = 1'b0;
    w_is_br   = 1'b0;
    w_ecall   = 1'b0;
    w_ebreak  = 1'b0;
    w_alu_op  = ALU_ADD;
    w_alu_a   = w_rs1_val;
    w_alu_b   = w_imm_i;
    case (w_opc)
      OPC_OP: begin
        w_legal   = (w_f7 == 7'b0000000) ||
                    ((w_f7 == 7'b0100000) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)));
        w_use_rd  = 1'b1;
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
        w_alu_op  = alu_decode(w_f3, w_f7[5], 1'b1);
        w_alu_b   = w_rs2_val;
      end
      OPC_OP_IMM: begin
        w_legal   = (w_f3 == 3'b001) ? (w_f7 == 7'b0000000) :
                    (w_f3 == 3'b101) ? ((w_f7 == 7'b0000000) || (w_f7 == 7'b0100000)) : 1'b1;
        w_use_rd  = 1'b1;
        w_use_rs1 = 1'b1;
        w_alu_op  = alu_decode(w_f3, w_f7[5], 1'b0);
      end
      OPC_LOAD: begin
        w_legal   = (w_f3 != 3'b011) && (w_f3[2:1] != 2'b11);
        w_use_rd  = 1'b1;
        w_use_rs1 = 1'b1;
        w_is_ld   = 1'b1;
      end
      OPC_STORE: begin
        w_legal   = !w_f3[2] && (w_f3[1:0] != 2'b11);
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
        w_is_st   = 1'b1;
        w_alu_b   = w_imm_s;
      end
      OPC_BRANCH: begin
        w_legal   = (w_f3[2:1] != 2'b01);
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
        w_is_br   = 1'b1;
        w_alu_b   = w_rs2_val;
      end
      OPC_JAL: begin
        w_legal  = 1'b1;
        w_use_rd = 1'b1;
      end
      OPC_JALR: begin
        w_legal   = (w_f3 == 3'b000);
        w_use_rd  = 1'b1;
        w_use_rs1 = 1'b1;
      end
      OPC_LUI: begin
        w_legal  = 1'b1;
        w_use_rd = 1'b1;
        w_alu_a  = 32'd0;
        w_alu_b  = w_imm_u;
      end
      OPC_AUIPC: begin
        w_legal  = 1'b1;
        w_use_rd = 1'b1;
        w_alu_a  = r_pc;
        w_alu_b  = w_imm_u;
      end
      OPC_SYSTEM: begin
        w_ecall  = (r_instr == 32'h0000_0073);
        w_ebreak = (r_instr == 32'h0010_0073);
        w_legal  = w_ecall || w_ebreak;
      end
      default: ;
    endcase
  end

  // Only RV32E builds can name a register that does not exist
  assign w_bad_reg = (NUM_REGS < 32) &&
                     ((w_use_rd && w_rd[4]) || (w_use_rs1 && w_rs1[4]) || (w_use_rs2 && w_rs2[4]));

  mc_core_alu u_alu (
    .i_op     (w_alu_op),
    .i_a      (w_alu_a),
    .i_b      (w_alu_b),
    .o_result (w_alu_res),
    .o_eq     (w_eq),
    .o_lt     (w_lt),
    .o_ltu    (w_ltu)
  );

  always_comb begin
    case (w_f3)
      3'b000:  w_taken = w_eq;
      3'b001:  w_taken = !w_eq;
      3'b100:  w_taken = w_lt;
      3'b101:  w_taken = !w_lt;
      3'b110:  w_taken = w_ltu;
      default: w_taken = !w_ltu;
    endcase
  end

  assign w_pc_plus4 = r_pc + 32'd4;

  always_comb begin
    w_jump    = 1'b0;
    w_next_pc = w_pc_plus4;
    if (w_opc == OPC_JAL) begin
      w_jump    = 1'b1;
      w_next_pc = r_pc + w_imm_j;
    end else if (w_opc == OPC_JALR) begin
      w_jump    = 1'b1;
      w_next_pc = {w_alu_res[31:1], 1'b0};
    end else if (w_is_br && w_taken) begin
      w_jump    = 1'b1;
      w_next_pc = r_pc + w_imm_b;
    end
  end

  assign w_ld_mis = w_is_ld && (((w_f3[1:0] == 2'b01) && w_alu_res[0]) ||
                                ((w_f3[1:0] == 2'b10) && (w_alu_res[1:0] != 2'b00)));
  assign w_st_mis = w_is_st && (((w_f3[1:0] == 2'b01) && w_alu_res[0]) ||
                                ((w_f3[1:0] == 2'b10) && (w_alu_res[1:0] != 2'b00)));

  always_comb begin
    w_exec_cause = TC_NONE;
    if (!w_legal || w_bad_reg)       w_exec_cause = TC_ILLEGAL;
    else if (w_ecall)                w_exec_cause = TC_ECALL;
    else if (w_ebreak)               w_exec_cause = TC_EBREAK;
    else if (w_jump && w_next_pc[1]) w_exec_cause = TC_MISALIGN_PC;
    else if (w_ld_mis)               w_exec_cause = TC_MISALIGN_LD;
    else if (w_st_mis)               w_exec_cause = TC_MISALIGN_ST;
  end

  // The request is gated by reset_n so it drops in the very cycle reset asserts
  assign w_bus_phase = (r_state == ST_FETCH) || (r_state == ST_MEM);
  assign mem_valid   = reset_n && w_bus_phase;
  assign mem_instr   = reset_n && (r_state == ST_FETCH);
  assign mem_addr    = (r_state == ST_FETCH) ? r_pc : {w_alu_res[31:2], 2'b00};

  always_comb begin
    case (w_f3[1:0])
      2'b00:   begin mem_wdata = {4{w_rs2_val[7:0]}};  w_strb = 4'b0001 << w_alu_res[1:0]; end
      2'b01:   begin mem_wdata = {2{w_rs2_val[15:0]}}; w_strb = 4'b0011 << w_alu_res[1:0]; end
      default: begin mem_wdata = w_rs2_val;            w_strb = 4'b1111; end
    endcase
  end

  assign mem_wstrb = (mem_valid && (r_state == ST_MEM) && w_is_st) ? w_strb : 4'b0000;

  assign w_lane = r_rdata >> {w_alu_res[1:0], 3'b000};

  always_comb begin
    case (w_f3)
      3'b000:  w_load_val = {{24{w_lane[7]}}, w_lane[7:0]};
      3'b001:  w_load_val = {{16{w_lane[15]}}, w_lane[15:0]};
      3'b100:  w_load_val = {24'd0, w_lane[7:0]};
      3'b101:  w_load_val = {16'd0, w_lane[15:0]};
      default: w_load_val = r_rdata;
    endcase
  end

  assign w_wb_val = w_is_ld ? w_load_val :
                    ((w_opc == OPC_JAL) || (w_opc == OPC_JALR)) ? w_pc_plus4 : w_alu_res;

  // Expiry only when the transfer is still pending; a same-cycle ready wins
  assign w_waiting = w_bus_phase && !mem_ready;
  assign w_expire  = (BUS_TIMEOUT != 0) && w_waiting && (r_wait == TCW'(BUS_TIMEOUT - 1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_FETCH: begin
        if (mem_ready)     w_state_nxt = ST_EXEC;
        else if (w_expire) w_state_nxt = ST_TRAP;
      end
      ST_EXEC: begin
        if (w_exec_cause != TC_NONE) w_state_nxt = ST_TRAP;
        else if (w_is_ld || w_is_st) w_state_nxt = ST_MEM;
        else                         w_state_nxt = ST_WB;
      end
      ST_MEM: begin
        if (mem_ready)     w_state_nxt = ST_WB;
        else if (w_expire) w_state_nxt = ST_TRAP;
      end
      ST_WB:   w_state_nxt = ST_FETCH;
      ST_TRAP: w_state_nxt = ST_TRAP;
      default: w_state_nxt = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= ST_FETCH;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pc    <= RESET_PC;
      r_instr <= 32'd0;
      r_rdata <= 32'd0;
      r_cause <= TC_NONE;
      r_wait  <= '0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= 32'd0;
    end else begin
      r_wait <= w_waiting ? r_wait + 1'b1 : '0;
      case (r_state)
        ST_FETCH: begin
          if (mem_ready)     r_instr <= mem_rdata;
          else if (w_expire) r_cause <= TC_BUS_TIMEOUT;
        end
        ST_EXEC: begin
          if (w_exec_cause != TC_NONE) r_cause <= w_exec_cause;
        end
        ST_MEM: begin
          if (mem_ready)     r_rdata <= mem_rdata;
          else if (w_expire) r_cause <= TC_BUS_TIMEOUT;
        end
        ST_WB: begin
          if (w_use_rd && (w_rd != 5'd0)) r_regs[w_rd[RIW-1:0]] <= w_wb_val;
          r_pc <= w_next_pc;
        end
        default: ;
      endcase
    end
  end

  assign halted     = (r_state == ST_TRAP);
  assign trap_cause = r_cause;
  assign peek       = r_pc;

`ifdef MC_CORE_TRACE_EN
  assign retire_valid = (r_state == ST_WB);
  assign retire_pc    = r_pc;
  assign retire_instr = r_instr;
`endif

endmodule

`default_nettype wire
